// File: rtl/sar_cap_dac_ctrl.sv
// SAR conversion engine around an ideal charge-redistribution cap DAC: samples vi,
// runs a vcm-referenced binary search over ADC_BITS decisions and returns a parallel code.
module sar_cap_dac_ctrl #(
    parameter int  ADC_BITS                  = 8,
    parameter real UNIT_CAP                  = 1.0e-15,
    parameter real PAR_CAP                   = 0.0,
    parameter int  DAC_CAPS [1:ADC_BITS-1]   = '{default: 0},
    parameter real COMP_OFFSET               = 0.0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                cal_mode,
    input  logic [ADC_BITS-1:1] cal_h,
    input  logic [ADC_BITS-1:1] cal_l,
    input  real                 vi,
    input  real                 vcm,
    input  real                 vrefp,
    input  real                 vrefn,
    output logic                busy,
    output logic [ADC_BITS-1:0] dout,
    output logic                dout_valid,
    output logic [ADC_BITS-1:1] dac_data_h,
    output logic [ADC_BITS-1:1] dac_data_l,
    output real                 vo,
    output logic                comp_out
);

    localparam int KW = $clog2(ADC_BITS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        CONV   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [KW-1:0]       bit_idx;
    logic [ADC_BITS-1:1] dout_int;
    logic [ADC_BITS-1:1] cap_h;
    logic [ADC_BITS-1:1] cap_l;
    logic                comp;
    real                 vs;
    real                 c_tot;
    real                 c_p;
    real                 c_n;
    real                 c_x;

    // Cap sizes in unit-cap multiples; a zero entry means the ideal binary weight.
    function automatic real cap_units(input int i);
        if (DAC_CAPS[i] == 0) return real'(1 << (i - 1));
        return real'(DAC_CAPS[i]);
    endfunction

    // Charge sums are kept in unit-cap multiples so binary-weighted results stay exact.
    always_comb begin
        c_tot = 1.0 + PAR_CAP / UNIT_CAP;
        c_p   = 0.0;
        c_n   = 0.0;
        c_x   = 1.0;
        for (int i = 1; i < ADC_BITS; i++) begin
            c_tot = c_tot + cap_units(i);
            if (cap_h[i] && !cap_l[i])
                c_p = c_p + cap_units(i);
            else if (!cap_h[i] && cap_l[i])
                c_n = c_n + cap_units(i);
            else
                c_x = c_x + cap_units(i);
        end
        vo = (c_tot * vs + c_p * vrefp + c_n * vrefn - (c_tot - c_x) * vcm) / c_tot;
    end

    assign comp = (vo > vcm + COMP_OFFSET);

    // Handshake: start is taken only when busy is low (IDLE, cal_mode low); busy then stays
    // high through the dout_valid cycle, and start seen while busy is dropped, not queued.
    assign busy       = (state != IDLE);
    assign dout_valid = (state == DONE);
    assign dac_data_h = cap_h;
    assign dac_data_l = cap_l;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !cal_mode) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = CONV;
            CONV:    if (bit_idx == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            bit_idx  <= '0;
            dout_int <= '0;
            dout     <= '0;
            cap_h    <= '0;
            cap_l    <= '0;
            comp_out <= 1'b0;
            vs       <= 0.0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    cap_h <= cal_mode ? cal_h : '0;
                    cap_l <= cal_mode ? cal_l : '0;
                end
                SAMPLE: begin
                    vs      <= vi;
                    cap_h   <= '0;
                    cap_l   <= '0;
                    bit_idx <= KW'(ADC_BITS - 1);
                end
                CONV: begin
                    comp_out <= comp;
                    bit_idx  <= bit_idx - 1'b1;
                    // A high decision pulls this cap to vrefn, a low one to vrefp.
                    if (bit_idx != '0) begin
                        dout_int[bit_idx] <= comp;
                        cap_h[bit_idx]    <= ~comp;
                        cap_l[bit_idx]    <= comp;
                    end else begin
                        dout <= {dout_int, comp};
                    end
                end
                DONE: begin
                    cap_h <= '0;
                    cap_l <= '0;
                end
                default: ;
            endcase
        end
    end

    // (h,l) = (1,1) shorts the references; the charge model above treats it as vcm.
    always_ff @(posedge clock) begin
        illegal_sel_check: assert (reset || ((cap_h & cap_l) == '0))
            else $error("sar_cap_dac_ctrl: illegal cap select h=%b l=%b", cap_h, cap_l);
    end

endmodule

// File: tb/tb_sar_cap_dac_ctrl.sv
// Bench for sar_cap_dac_ctrl: an ideal-weight instance and a mismatched-MSB instance share
// stimulus; a successive-approximation model predicts timing and codes for both.
module tb_sar_cap_dac_ctrl;
  localparam int N = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         cal_mode = 1'b0;
  logic [N-1:1] cal_h = '0;
  logic [N-1:1] cal_l = '0;
  real          vi = 0.0;
  real          vcm = 0.5;
  real          vrefp = 1.0;
  real          vrefn = 0.0;

  logic         busy_a, dv_a, comp_a, busy_b, dv_b, comp_b;
  logic [N-1:0] dout_a, dout_b;
  logic [N-1:1] dh_a, dl_a, dh_b, dl_b;
  real          vo_a, vo_b;

  int n_vec = 0;
  int n_err = 0;
  int n_valid = 0;

  sar_cap_dac_ctrl #(.ADC_BITS(N)) u_bin (
    .clock(clock), .reset(reset), .start(start), .cal_mode(cal_mode),
    .cal_h(cal_h), .cal_l(cal_l), .vi(vi), .vcm(vcm), .vrefp(vrefp), .vrefn(vrefn),
    .busy(busy_a), .dout(dout_a), .dout_valid(dv_a), .dac_data_h(dh_a),
    .dac_data_l(dl_a), .vo(vo_a), .comp_out(comp_a)
  );

  sar_cap_dac_ctrl #(.ADC_BITS(N), .DAC_CAPS('{1, 2, 4, 8, 16, 32, 66})) u_mis (
    .clock(clock), .reset(reset), .start(start), .cal_mode(cal_mode),
    .cal_h(cal_h), .cal_l(cal_l), .vi(vi), .vcm(vcm), .vrefp(vrefp), .vrefn(vrefn),
    .busy(busy_b), .dout(dout_b), .dout_valid(dv_b), .dac_data_h(dh_b),
    .dac_data_l(dl_b), .vo(vo_b), .comp_out(comp_b)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_r(input string name, input real act, input real exp);
    real d;
    n_vec++;
    d = act - exp;
    if (d < 0.0) d = -d;
    if (d > 1.0e-9) begin
      n_err++;
      $display("FAIL %s: got %f, expected %f (t=%0t)", name, act, exp, $time);
    end
  endtask

  // model: cap weights in units, then successive approximation on the node voltage
  function automatic real wt(input bit mis, input int i);
    if (mis && i == N - 1) return 66.0;
    return real'(1 << (i - 1));
  endfunction

  function automatic void ref_conv(input real v, input bit mis, output int code,
                                   output real margin);
    real ctot, x, d;
    ctot = 1.0;
    for (int i = 1; i < N; i++) ctot += wt(mis, i);
    x = v;
    code = 0;
    margin = 1.0;
    for (int b = N - 1; b >= 0; b--) begin
      d = (x > vcm) ? x - vcm : vcm - x;
      if (d < margin) margin = d;
      if (x > vcm) begin
        code = code | (1 << b);
        if (b > 0) x = x - wt(mis, b) / ctot * (vcm - vrefn);
      end else if (b > 0) begin
        x = x + wt(mis, b) / ctot * (vrefp - vcm);
      end
    end
  endfunction

  // scoreboard state: phase = cycles since start acceptance (0 = idle)
  int           phase = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] exp_q_mis[$];
  bit           ok_q_mis[$];

  initial begin : model_proc
    int  c;
    real m;
    forever begin
      @(posedge clock);
      if (reset) begin
        phase = 0;
        exp_q.delete();
        exp_q_mis.delete();
        ok_q_mis.delete();
      end else if (phase == 0) begin
        if (start && !cal_mode) phase = 1;
      end else begin
        if (phase == 1) begin
          ref_conv(vi, 1'b0, c, m);
          exp_q.push_back(c[N-1:0]);
          ref_conv(vi, 1'b1, c, m);
          exp_q_mis.push_back(c[N-1:0]);
          ok_q_mis.push_back(m > 1.0e-9);
        end
        if (phase == N + 2) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          if (exp_q_mis.size() > 0) void'(exp_q_mis.pop_front());
          if (ok_q_mis.size() > 0) void'(ok_q_mis.pop_front());
          phase = 0;
        end else begin
          phase = phase + 1;
        end
      end
    end
  end

  initial begin : compare_proc
    bit exp_busy, exp_valid;
    forever begin
      @(negedge clock);
      exp_busy  = (phase >= 1);
      exp_valid = (phase == N + 2);
      chk("busy", busy_a, exp_busy);
      chk("busy_mis", busy_b, exp_busy);
      chk("dout_valid", dv_a, exp_valid);
      chk("dout_valid_mis", dv_b, exp_valid);
      if (dv_a) n_valid++;
      if (exp_valid) begin
        if (exp_q.size() == 0) begin
          chk("exp_q_empty", 0, 1);
        end else begin
          chk("dout", dout_a, exp_q[0]);
          chk("comp_out_lsb", comp_a, exp_q[0][0]);
          if (ok_q_mis[0]) chk("dout_mis", dout_b, exp_q_mis[0]);
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic convert(input real v, input bit late, input real v_late,
                         output logic [N-1:0] code, output int lat, output int busy_cnt);
    bit got;
    step();
    vi = v;
    start = 1'b1;
    step();
    start = 1'b0;
    got = 1'b0;
    lat = 0;
    busy_cnt = 0;
    code = '0;
    for (int i = 1; i <= 30 && !got; i++) begin
      @(negedge clock);
      if (late && i == 2) vi = v_late;
      if (busy_a) busy_cnt++;
      if (dv_a) begin
        got = 1'b1;
        lat = i;
        code = dout_a;
      end
    end
    if (!got) chk("convert_timeout", 0, 1);
  endtask

  initial begin : main
    logic [N-1:0] code, prev;
    int lat, bc, v0, c;
    real m, v;

    // model pinned to hand-computed codes
    ref_conv(0.7, 1'b0, c, m);  chk("model_0p7", c, 179);
    ref_conv(0.0, 1'b0, c, m);  chk("model_0p0", c, 0);
    ref_conv(1.0, 1'b0, c, m);  chk("model_1p0", c, 255);
    ref_conv(0.5, 1'b0, c, m);  chk("model_0p5", c, 127);

    repeat (3) step();
    @(negedge clock);
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", dv_a, 0);
    chk("rst_dout", dout_a, 0);
    chk("rst_dac_h", dh_a, 0);
    chk("rst_dac_l", dl_a, 0);
    chk("rst_comp", comp_a, 0);
    chk_r("rst_vo", vo_a, 0.0);
    step();
    reset = 1'b0;

    convert(0.7, 1'b0, 0.0, code, lat, bc);
    chk("vi0p7_code", code, 8'hB3);
    chk("vi0p7_latency", lat, 10);
    chk("vi0p7_busy_cycles", bc, 10);
    convert(0.0, 1'b0, 0.0, code, lat, bc);  chk("vi0p0_code", code, 8'h00);
    convert(1.0, 1'b0, 0.0, code, lat, bc);  chk("vi1p0_code", code, 8'hFF);
    convert(0.5, 1'b0, 0.0, code, lat, bc);  chk("vi0p5_code", code, 8'h7F);

    // input moves during CONV: the held sample must win
    convert(0.2, 1'b1, 0.9, code, lat, bc);
    ref_conv(0.2, 1'b0, c, m);
    chk("vi_late_code", code, c);

    // mismatched-MSB instance at off-tie inputs (checked by compare_proc)
    convert(0.33, 1'b0, 0.0, code, lat, bc);
    convert(0.61, 1'b0, 0.0, code, lat, bc);
    convert(0.7, 1'b0, 0.0, code, lat, bc);
    convert(0.82, 1'b0, 0.0, code, lat, bc);

    // start re-pulsed while busy
    step();
    v0 = n_valid;
    vi = 0.4;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();
    chk("repulse_valid_count", n_valid - v0, 1);

    // start held high: one conversion every N+3 cycles
    v0 = n_valid;
    vi = 0.66;
    start = 1'b1;
    repeat (2 * (N + 3)) step();
    start = 1'b0;
    repeat (15) step();
    chk("back_to_back_count", n_valid - v0, 2);

    // reset during the fourth CONV cycle
    v0 = n_valid;
    vi = 0.9;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_dac_h", dh_a, 0);
    chk("midrst_dac_l", dl_a, 0);
    chk("midrst_comp", comp_a, 0);
    repeat (15) step();
    chk("midrst_no_valid", n_valid - v0, 0);
    convert(0.7, 1'b0, 0.0, code, lat, bc);
    chk("post_rst_code", code, 8'hB3);

    // manual calibration drive, held sample 0.3
    convert(0.3, 1'b0, 0.0, code, lat, bc);
    step();
    cal_mode = 1'b1;
    cal_h = 7'h40;
    cal_l = 7'h00;
    start = 1'b1;
    @(negedge clock);
    chk("cal_latency_h", dh_a, 0);
    step();
    @(negedge clock);
    chk("cal_dac_h", dh_a, 7'h40);
    chk("cal_dac_l", dl_a, 7'h00);
    chk_r("cal_vo_msb", vo_a, 0.3 + 0.25);
    chk_r("cal_vo_msb_mis", vo_b, 0.3 + 66.0 / 130.0 * 0.5);
    step();
    cal_h = 7'h00;
    cal_l = 7'h01;
    step();
    @(negedge clock);
    chk("cal_dac_l1", dl_a, 7'h01);
    chk_r("cal_vo_lsb", vo_a, 0.3 - 0.5 / 128.0);
    start = 1'b0;
    cal_mode = 1'b0;
    cal_l = 7'h00;
    repeat (2) step();
    @(negedge clock);
    chk_r("cal_exit_vo", vo_a, 0.3);

    // sweep in 1/512 steps
    prev = '0;
    for (int n = 0; n <= 512; n++) begin
      v = real'(n) / 512.0;
      convert(v, 1'b0, 0.0, code, lat, bc);
      c = int'(code) - int'($floor(v * 256.0));
      chk("sweep_within_1lsb", (c >= -1 && c <= 1), 1);
      if (n > 0) chk("sweep_monotonic", (code >= prev), 1);
      prev = code;
    end

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
